// File: rtl/tile_pkg.sv
// tile_pkg: shared constants and types for the brick/tile map.
//   Screen/tile geometry, default-level band, row word type,
//   write-FSM state enum and the default-level row generator.
package tile_pkg;

    localparam int TILE_W     = 32;
    localparam int TILE_H     = 16;
    localparam int COLS       = 20;
    localparam int ROWS       = 30;
    localparam int H_VIS      = 640;
    localparam int V_VIS      = 480;
    localparam int V_TOTAL    = 525;
    localparam int INIT_FIRST = 2;
    localparam int INIT_LAST  = 7;

    localparam int ROW_AW = 5;
    localparam int TX_SH  = $clog2(TILE_W);
    localparam int TY_SH  = $clog2(TILE_H);
    localparam int CNT_W  = 10;

    // Sized copies so comparisons against 10/5-bit signals stay width-clean.
    localparam logic [9:0]        H_VIS_X    = 10'(H_VIS);
    localparam logic [9:0]        V_VIS_Y    = 10'(V_VIS);
    localparam logic [9:0]        V_LAST_Y   = 10'(V_TOTAL - 1);
    localparam logic [ROW_AW-1:0] ROW_LIM    = ROW_AW'(ROWS);
    localparam logic [ROW_AW-1:0] COL_LIM    = ROW_AW'(COLS);
    localparam logic [ROW_AW-1:0] ROW_LAST   = ROW_AW'(ROWS - 1);
    localparam logic [CNT_W-1:0]  INIT_COUNT = CNT_W'((INIT_LAST - INIT_FIRST + 1) * COLS);

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {IDLE, RD, WR} wr_state_t;

    // Row word of the default level: a solid band of bricks, empty elsewhere.
    function automatic row_t init_row_word(input logic [ROW_AW-1:0] r);
        logic in_band;
        in_band = (int'(r) >= INIT_FIRST) && (int'(r) <= INIT_LAST);
        return {COLS{in_band}};
    endfunction

endpackage

// File: rtl/tile_row_ram.sv
// tile_row_ram: single-port ROWS x row_t store, one full row per access.
//   clk_i/rst_i : clock, async active-high clear of every row
//   en_i        : access this cycle
//   we_i        : 1 = write wdata_i to addr_i, 0 = read addr_i
//   rdata_o     : registered read data, valid the cycle after a read
module tile_row_ram
    import tile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ROW_AW-1:0] addr_i,
    input  row_t              wdata_i,
    output row_t              rdata_o
);

    row_t mem_q [ROWS];
    row_t rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_map_controller.sv
// tile_map_controller: owns the tile map and drives per-pixel tile_on.
//   Clk, Reset        : pixel clock, async active-high reset
//   DrawX, DrawY      : current scan position
//   wr_req/row/col/val: game-logic single-tile write, held until wr_ack
//   wr_ack            : write committed this cycle (one-cycle pulse)
//   init_req, busy    : default-level load request / load in progress
//   tile_on           : tile present at (DrawX, DrawY)
//   tiles_left        : number of set tiles in the map
// The row store port goes to the line fetch first, then the init
// sequencer, then the read-modify-write of the write FSM.
module tile_map_controller
    import tile_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        wr_req,
    input  logic [4:0]  wr_row,
    input  logic [4:0]  wr_col,
    input  logic        wr_val,
    output logic        wr_ack,
    input  logic        init_req,
    output logic        busy,
    output logic        tile_on,
    output logic [9:0]  tiles_left
);

    wr_state_t         state_q, state_d;
    logic              fetch, fetch_vis;
    logic [9:0]        next_y;
    logic              fetch_q, fetch_vis_q;
    row_t              line_buf_q;
    logic              line_valid_q;
    logic              rd_done_q;
    row_t              hold_q, row_cur, new_row;
    logic              old_bit, wr_in_range;
    logic              busy_q, busy_d;
    logic [ROW_AW-1:0] init_row_q, init_row_d;
    logic              init_pend_q, init_pend_d;
    logic              start_init, init_step, init_done;
    logic [CNT_W-1:0]  tiles_q, tiles_d;
    logic              ram_en, ram_we;
    logic [ROW_AW-1:0] ram_addr;
    row_t              ram_wdata, ram_rdata;

    tile_row_ram u_ram (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // ---------------- display line fetch ----------------
    assign fetch     = (DrawX == H_VIS_X);
    assign next_y    = (DrawY == V_LAST_Y) ? '0 : DrawY + 10'd1;
    assign fetch_vis = (next_y < V_VIS_Y);

    // Read data arrives the cycle after the fetch; latching then (still in
    // horizontal blanking) keeps the visible line tear-free.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_q      <= 1'b0;
            fetch_vis_q  <= 1'b0;
            line_buf_q   <= '0;
            line_valid_q <= 1'b0;
        end else begin
            fetch_q     <= fetch;
            fetch_vis_q <= fetch && fetch_vis;
            if (fetch_q) begin
                line_valid_q <= fetch_vis_q;
                if (fetch_vis_q) line_buf_q <= ram_rdata;
            end
        end
    end

    assign tile_on = line_valid_q && (DrawX < H_VIS_X) && (DrawY < V_VIS_Y)
                     && line_buf_q[DrawX[9:TX_SH]];

    // ---------------- port arbitration ----------------
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (fetch) begin
            ram_en   = fetch_vis;
            ram_addr = ROW_AW'(next_y >> TY_SH);
        end else if (busy_q) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = init_row_q;
            ram_wdata = init_row_word(init_row_q);
        end else if (state_q == RD) begin
            ram_en   = wr_in_range;
            ram_addr = wr_row;
        end else if (state_q == WR) begin
            ram_en    = wr_in_range;
            ram_we    = wr_in_range;
            ram_addr  = wr_row;
            ram_wdata = new_row;
        end
    end

    // ---------------- init sequencer ----------------
    // A request seen while a write is mid-flight is parked in init_pend_q
    // and launched once the FSM is back in IDLE; requests during busy drop.
    always_comb begin
        start_init  = (init_req || init_pend_q) && !busy_q && (state_q == IDLE);
        init_pend_d = (init_req || init_pend_q) && !busy_q && !start_init;
        init_step   = busy_q && !fetch;
        init_done   = init_step && (init_row_q == ROW_LAST);
        busy_d      = busy_q;
        init_row_d  = init_row_q;
        if (start_init) begin
            busy_d     = 1'b1;
            init_row_d = '0;
        end else if (init_step) begin
            init_row_d = init_row_q + 5'd1;
            if (init_done) busy_d = 1'b0;
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (wr_req && !busy_q && !start_init) state_d = RD;
            RD:      if (!fetch) state_d = WR;
            WR:      if (!fetch) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ack = (state_q == WR) && !fetch;
    end

    assign wr_in_range = (wr_row < ROW_LIM) && (wr_col < COL_LIM);

    // Read data is only on the RAM output the cycle after RD; a fetch that
    // stalls WR overwrites it, so later WR cycles use the held copy.
    always_comb begin
        row_cur = rd_done_q ? ram_rdata : hold_q;
        new_row = row_cur;
        old_bit = 1'b0;
        if (wr_col < COL_LIM) begin
            old_bit         = row_cur[wr_col];
            new_row[wr_col] = wr_val;
        end
    end

    always_comb begin
        tiles_d = tiles_q;
        if (init_done) begin
            tiles_d = INIT_COUNT;
        end else if (wr_ack && wr_in_range) begin
            if (!old_bit && wr_val)      tiles_d = tiles_q + 10'd1;
            else if (old_bit && !wr_val) tiles_d = tiles_q - 10'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q      <= 1'b0;
            init_row_q  <= '0;
            init_pend_q <= 1'b0;
            tiles_q     <= '0;
            rd_done_q   <= 1'b0;
            hold_q      <= '0;
        end else begin
            busy_q      <= busy_d;
            init_row_q  <= init_row_d;
            init_pend_q <= init_pend_d;
            tiles_q     <= tiles_d;
            rd_done_q   <= (state_q == RD) && !fetch;
            if (state_q == WR) hold_q <= row_cur;
        end
    end

    assign busy       = busy_q;
    assign tiles_left = tiles_q;

endmodule

// File: tb/tb_tile_map_controller.sv
module tb_tile_map_controller;
    import tile_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       wr_req;
    logic [4:0] wr_row, wr_col;
    logic       wr_val, wr_ack, init_req, busy, tile_on;
    logic [9:0] tiles_left;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    tile_map_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .wr_req     (wr_req),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_val     (wr_val),
        .wr_ack     (wr_ack),
        .init_req   (init_req),
        .busy       (busy),
        .tile_on    (tile_on),
        .tiles_left (tiles_left)
    );

    // Reference: the map as a plain bit grid plus the line last fetched.
    bit map [ROWS][COLS];
    bit mline [COLS];
    bit mvalid = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int count_map();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) n += map[r][c];
        return n;
    endfunction

    function automatic void model_init();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) map[r][c] = (r >= 2 && r <= 7);
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) map[r][c] = 1'b0;
        mvalid = 1'b0;
    endfunction

    function automatic int nexty(input int y);
        return (y == V_TOTAL - 1) ? 0 : y + 1;
    endfunction

    function automatic void model_fetch(input int ycur);
        int ny = nexty(ycur);
        if (ny < V_VIS) begin
            mvalid = 1'b1;
            for (int c = 0; c < COLS; c++) mline[c] = map[ny / TILE_H][c];
        end else begin
            mvalid = 1'b0;
        end
    endfunction

    task automatic fetch_line(input int y);
        @(negedge Clk);
        DrawY = 10'((y == 0) ? V_TOTAL - 1 : y - 1);
        DrawX = 10'd640;
        #1 model_fetch(int'(DrawY));
        @(negedge Clk);
        DrawX = 10'd700;
    endtask

    task automatic chk_line(input int y, input bit full);
        for (int x = 0; x < H_VIS; x += (full ? 1 : TILE_W)) begin
            int xx = full ? x : x + int'($urandom_range(0, TILE_W - 1));
            @(negedge Clk);
            DrawY = 10'(y);
            DrawX = 10'(xx);
            #1 chk($sformatf("tile_on y%0d x%0d", y, xx), tile_on,
                   int'(mvalid && y < V_VIS && mline[xx / TILE_W]));
        end
        @(negedge Clk);
        DrawX = 10'd700;
    endtask

    // One write. fm[i] puts a line fetch (DrawX==640) in cycle i, cycle 0
    // being the request cycle. The write needs two port-granted cycles after
    // the request cycle; the second of them carries the ack.
    task automatic do_write(input string tag, input int row, input int col,
                            input int val, input logic [7:0] fm, input int ycur);
        int exp_ack = -1;
        int got_ack = -1;
        int g = 0;
        for (int i = 1; i < 8; i++)
            if (!fm[i]) begin
                g++;
                if (g == 2 && exp_ack < 0) exp_ack = i;
            end
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            wr_req = 1'b1;
            wr_row = 5'(row);
            wr_col = 5'(col);
            wr_val = val[0];
            DrawY  = 10'(ycur);
            DrawX  = (c < 8 && fm[c]) ? 10'd640 : 10'd700;
            #1;
            if (c < 8 && fm[c]) model_fetch(ycur);
            if (wr_ack) begin
                got_ack = c;
                break;
            end
        end
        if (row < ROWS && col < COLS) map[row][col] = val[0];
        @(negedge Clk);
        wr_req = 1'b0;
        DrawX  = 10'd700;
        #1;
        chk({tag, " ack_cycle"}, got_ack, exp_ack);
        chk({tag, " ack_pulse"}, wr_ack, 0);
        chk({tag, " tiles_left"}, tiles_left, count_map());
    endtask

    // init_req pulse, random fetches during the load, optional extra
    // init_req while busy (must be ignored).
    task automatic run_init(input int fetch_pct, input int extra);
        int granted = 0;
        bit f;
        @(negedge Clk);
        init_req = 1'b1;
        DrawX    = 10'd700;
        DrawY    = 10'd500;
        #1 chk("init busy_before", busy, 0);
        for (int c = 1; c < 200; c++) begin
            @(negedge Clk);
            init_req = (c == extra);
            f = ($urandom_range(0, 99) < fetch_pct);
            DrawX = f ? 10'd640 : 10'd700;
            #1;
            if (f) mvalid = 1'b0;
            if (!busy) break;
            if (!f) granted++;
        end
        init_req = 1'b0;
        DrawX    = 10'd700;
        model_init();
        chk("init granted_cycles", granted, ROWS);
        chk("init tiles_left", tiles_left, count_map());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        DrawX = 10'd700; DrawY = 10'd500;
        wr_req = 1'b0; wr_row = '0; wr_col = '0; wr_val = 1'b0; init_req = 1'b0;
        model_clear();
        repeat (3) @(negedge Clk);
        DrawX = 10'd0; DrawY = 10'd0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset tiles_left", tiles_left, 0);
        chk("reset wr_ack", wr_ack, 0);
        chk("reset tile_on", tile_on, 0);
        @(negedge Clk);
        Reset = 1'b0;
        DrawX = 10'd700; DrawY = 10'd500;

        // Default level, fetches sprinkled in, second request ignored.
        run_init(20, 5);
        fetch_line(32);  chk_line(32, 1'b1);
        fetch_line(0);   chk_line(0, 1'b0);

        // Destroy (3,5) without collision, then inspect its lines.
        do_write("w3_5", 3, 5, 0, 8'h00, 500);
        fetch_line(48);  chk_line(48, 1'b0);
        fetch_line(63);  chk_line(63, 1'b0);
        fetch_line(47);  chk_line(47, 1'b0);
        fetch_line(64);  chk_line(64, 1'b0);

        // Fetch lands on RD, then on WR; line fetched during RD sees the old row.
        do_write("rd_coll", 4, 6, 0, 8'h02, 63);
        chk_line(64, 1'b0);
        fetch_line(64);  chk_line(64, 1'b0);
        do_write("wr_coll", 5, 7, 0, 8'h04, 79);
        fetch_line(80);  chk_line(80, 1'b0);

        // Redundant and out-of-range writes.
        do_write("w3_5_again", 3, 5, 0, 8'h00, 500);
        do_write("row31", 31, 2, 1, 8'h00, 500);
        do_write("col25", 2, 25, 0, 8'h00, 500);

        // Random writes with random fetch collisions.
        for (int k = 0; k < 30; k++) begin
            int row  = $urandom_range(0, 31);
            int col  = $urandom_range(0, 21);
            int val  = $urandom_range(0, 1);
            int ycur = $urandom_range(0, V_TOTAL - 1);
            logic [7:0] fm = 8'($urandom) & 8'h0F;
            do_write($sformatf("rnd%0d", k), row, col, val, fm, ycur);
            chk_line(nexty(ycur), 1'b0);
        end

        // init_req and wr_req together in IDLE: load first, then the write.
        begin
            int fell = -1, ack = -1, ack_busy = 0;
            @(negedge Clk);
            init_req = 1'b1; wr_req = 1'b1; wr_row = 5'd10; wr_col = 5'd3; wr_val = 1'b1;
            DrawX = 10'd700;
            #1 chk("both ack_at_req", wr_ack, 0);
            for (int c = 1; c < 80; c++) begin
                @(negedge Clk);
                init_req = 1'b0;
                #1;
                if (busy && wr_ack) ack_busy++;
                if (!busy && fell < 0) fell = c;
                if (wr_ack) begin
                    ack = c;
                    break;
                end
            end
            @(negedge Clk);
            wr_req = 1'b0;
            model_init();
            map[10][3] = 1'b1;
            #1;
            chk("both ack_while_busy", ack_busy, 0);
            chk("both busy_fall_cycle", fell, ROWS + 1);
            chk("both ack_after_init", ack - fell, 2);
            chk("both tiles_left", tiles_left, count_map());
            fetch_line(160); chk_line(160, 1'b0);
        end

        // init_req while the write FSM is in RD: write finishes, then load.
        begin
            int nbusy = 0;
            @(negedge Clk);
            wr_req = 1'b1; wr_row = 5'd6; wr_col = 5'd0; wr_val = 1'b0; DrawX = 10'd700;
            @(negedge Clk);
            init_req = 1'b1;
            #1 chk("mid ack_rd", wr_ack, 0);
            @(negedge Clk);
            init_req = 1'b0;
            #1 chk("mid ack_wr", wr_ack, 1);
            @(negedge Clk);
            wr_req = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge Clk);
                #1 if (busy) nbusy++;
            end
            model_init();
            chk("mid busy_cycles", nbusy, ROWS);
            chk("mid tiles_left", tiles_left, count_map());
        end

        // Reset in the middle of a load.
        @(negedge Clk);
        init_req = 1'b1;
        @(negedge Clk);
        init_req = 1'b0;
        repeat (8) @(negedge Clk);
        Reset = 1'b1;
        #1;
        model_clear();
        chk("rst_mid busy", busy, 0);
        chk("rst_mid tiles_left", tiles_left, 0);
        chk("rst_mid wr_ack", wr_ack, 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        #1 chk("rst_mid busy_after", busy, 0);
        fetch_line(32);  chk_line(32, 1'b0);
        fetch_line(100); chk_line(100, 1'b0);
        fetch_line(0);   chk_line(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_map_controller.md
Name: tile_map_controller

Overview:
- Owns the brick/tile map for the ball game and produces the per-pixel `tile_on` consumed by color_mapper.
- Holds a ROWS x COLS bit map in a single-port row-wide store (one row word per access).
- Arbitrates that port between three users:
  - the display line fetch, which has absolute priority;
  - game-logic tile writes, via req/ack;
  - a level-init sequencer.
- Maintains a running count of remaining tiles.

Parameters:
- TILE_W, 32, tile width in pixels (power of 2)
- TILE_H, 16, tile height in pixels (power of 2)
- COLS, 20, tiles per row (640/TILE_W)
- ROWS, 30, tile rows (480/TILE_H)
- H_VIS, 640, visible pixels per line
- V_VIS, 480, visible lines
- V_TOTAL, 525, total lines per frame

Ports:
- Clk, input, 1, pixel-rate clock; DrawX/DrawY advance at most once per cycle
- Reset, input, 1, asynchronous, active-high
- DrawX, input, 10, current pixel column from the VGA controller
- DrawY, input, 10, current line from the VGA controller
- wr_req, input, 1, game-logic write request; held until wr_ack
- wr_row, input, 5, target tile row (0..ROWS-1)
- wr_col, input, 5, target tile column (0..COLS-1)
- wr_val, input, 1, new tile bit (0 = destroy, 1 = place)
- wr_ack, output, 1, one-cycle pulse: write committed this cycle
- init_req, input, 1, pulse: load the default level
- busy, output, 1, init sequence in progress
- tile_on, output, 1, tile present at (DrawX, DrawY); goes to color_mapper
- tiles_left, output, 10, count of set tiles in the map

Behaviour:
- Reset (async) values:
  - all map bits 0, line buffer 0, line_valid 0;
  - wr_ack 0, busy 0, tiles_left 0, FSM in IDLE.
- Display fetch:
  - Fires in the cycle where DrawX == H_VIS.
  - next_y = (DrawY == V_TOTAL-1) ? 0 : DrawY+1.
  - If next_y < V_VIS: read row word next_y/TILE_H, latch it into line_buf the following cycle, set line_valid 1. Otherwise set line_valid 0.
  - The fetch always wins the port in its cycle. Any other user stalls one cycle and keeps its state.
- tile_on:
  - Combinational: line_valid && DrawX < H_VIS && DrawY < V_VIS && line_buf[DrawX/TILE_W].
  - Map updates become visible from the next line fetch onward; there is no tearing within a line.
- Write FSM, states IDLE -> RD -> WR -> IDLE:
  - IDLE: if wr_req && !busy, go to RD.
  - RD: read row wr_row into a hold register.
  - WR: write the row with bit wr_col set to wr_val, and pulse wr_ack.
  - tiles_left: +1 if the old bit was 0 and wr_val is 1; -1 if the old bit was 1 and wr_val is 0; otherwise unchanged.
  - A fetch colliding with RD or WR delays that step by one cycle.
  - Minimum latency is req to ack in 2 cycles.
  - wr_row >= ROWS or wr_col >= COLS: ack after RD with no write and no count change.
- Init sequencer:
  - On init_req: busy goes 1 and the sequencer writes rows 0..ROWS-1 in order, one per granted cycle.
  - Rows INIT_FIRST..INIT_LAST get all ones; every other row gets zero.
  - After the last row: busy goes 0 and tiles_left = (INIT_LAST-INIT_FIRST+1)*COLS.
- Init vs. writes:
  - init_req while the write FSM is in RD or WR: that write completes first, then init starts.
  - init_req while busy: ignored.
  - wr_req during busy: not acked; it is held off until init finishes.
- Simultaneous init_req and wr_req in IDLE: init wins.
- Reset mid-operation: everything returns to the reset values immediately; any pending write is lost.

Decomposition:
- tile_pkg holds: TILE_W, TILE_H, COLS, ROWS, H_VIS, V_VIS, V_TOTAL, INIT_FIRST=2, INIT_LAST=7, the row_t typedef (logic [COLS-1:0]), and the wr_state_t enum {IDLE, RD, WR}.
- One sub-module, tile_row_ram:
  - single-port, ROWS x row_t, async-reset clear;
  - registered read data (1-cycle latency), synchronous write.

Test Plan:
- Reset, then init_req pulse:
  - busy stays high for 30 port-granted cycles;
  - then tiles_left = 120;
  - at DrawY=32, DrawX=0..639 tile_on = 1; at DrawY=0, tile_on = 0.
- After init, write (row 3, col 5, val 0):
  - wr_ack 2 cycles after req (no fetch collision);
  - tiles_left = 119;
  - on the next frame, tile_on = 0 for DrawY=48..63, DrawX=160..191 only.
- Raise wr_req so RD lands on DrawX == 640:
  - ack delayed to 3 cycles;
  - line_buf for the next line is still correct.
- Write (row 3, col 5, val 0) again: ack issued, tiles_left stays 119.
- Write (row 31, col 2): ack issued, map and tiles_left unchanged.
- Assert init_req and wr_req in the same IDLE cycle:
  - init completes first;
  - the write is acked afterward;
  - a val 1 write to row 10 gives tiles_left = 121.
- Assert Reset mid-init: busy = 0, tiles_left = 0, tile_on = 0 everywhere on the next frame.
